// File: rtl/sd_cmd_framer.sv
// rtl/sd_cmd_framer.sv - SD SPI-mode command framer: sends a 6-byte frame, polls for R1, releases the card
// Drives the spi byte engine one byte per spi_en and reports R1 with a done pulse.
module sd_cmd_framer #(
  parameter int MAX_POLL = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_start,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  output logic        busy,
  output logic        done,
  output logic [7:0]  r1,
  output logic        timeout,
  output logic        cs_n,
  output logic [7:0]  spi_tx,
  output logic        spi_en,
  input  logic [7:0]  spi_rx,
  input  logic        spi_done
);

  typedef enum logic [2:0] {
    IDLE, SEND, WAIT, POLL, PWAIT, TRAIL, TWAIT
  } state_t;

  state_t      state;
  logic [39:0] rest;
  logic [2:0]  n;
  logic [7:0]  cnt;
  logic [39:0] head;

  assign head = {2'b01, cmd_index, cmd_arg};

  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      r1      <= 8'hFF;
      timeout <= 1'b0;
      cs_n    <= 1'b1;
      spi_en  <= 1'b0;
      spi_tx  <= 8'hFF;
      rest    <= '0;
      n       <= '0;
      cnt     <= '0;
    end else begin
      spi_en <= 1'b0;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_start) begin
            // B1..B5 are queued here; B0 goes out immediately.
            rest    <= {cmd_arg, crc7(head), 1'b1};
            spi_tx  <= head[39:32];
            spi_en  <= 1'b1;
            cs_n    <= 1'b0;
            busy    <= 1'b1;
            r1      <= 8'hFF;
            timeout <= 1'b0;
            n       <= 3'd0;
            state   <= SEND;
          end
        end
        SEND: state <= WAIT;
        WAIT: begin
          if (spi_done) begin
            spi_en <= 1'b1;
            if (n == 3'd5) begin
              spi_tx <= 8'hFF;
              cnt    <= 8'd1;
              state  <= POLL;
            end else begin
              spi_tx <= rest[39:32];
              rest   <= {rest[31:0], 8'h00};
              n      <= n + 3'd1;
              state  <= SEND;
            end
          end
        end
        POLL: state <= PWAIT;
        PWAIT: begin
          if (spi_done) begin
            if (!spi_rx[7] || cnt == 8'(MAX_POLL)) begin
              r1      <= spi_rx[7] ? 8'hFF : spi_rx;
              timeout <= spi_rx[7];
              // Card is deselected for the trailing release byte.
              cs_n    <= 1'b1;
              spi_tx  <= 8'hFF;
              spi_en  <= 1'b1;
              state   <= TRAIL;
            end else begin
              spi_en <= 1'b1;
              cnt    <= cnt + 8'd1;
              state  <= POLL;
            end
          end
        end
        TRAIL: state <= TWAIT;
        TWAIT: begin
          if (spi_done) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_cmd_framer.sv
// tb/tb_sd_cmd_framer.sv - scoreboard bench for sd_cmd_framer with a randomized spi engine and card model
module tb_sd_cmd_framer;
  localparam int MAXP = 8;

  logic        clk;
  logic        reset;
  logic        cmd_start;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        busy, done, timeout, cs_n, spi_en;
  logic [7:0]  r1, spi_tx, spi_rx;
  logic        mdone, spur;
  logic        spi_done;

  assign spi_done = mdone | spur;

  sd_cmd_framer #(.MAX_POLL(MAXP)) dut (
    .clk(clk), .reset(reset), .cmd_start(cmd_start), .cmd_index(cmd_index),
    .cmd_arg(cmd_arg), .busy(busy), .done(done), .r1(r1), .timeout(timeout),
    .cs_n(cs_n), .spi_tx(spi_tx), .spi_en(spi_en), .spi_rx(spi_rx),
    .spi_done(spi_done)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;
  int en_cnt = 0;
  int done_cnt = 0;
  logic prev_en = 0;

  logic [8:0] exp_tx[$];   // {cs_n, byte}
  logic [8:0] exp_res[$];  // {timeout, r1}
  logic [7:0] rx_q[$];

  // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1.
  function automatic logic [6:0] ref_crc(input logic [39:0] m);
    logic [46:0] v;
    v = {m, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (v[i]) v[i-:8] = v[i-:8] ^ 8'h89;
    return v[6:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // spi engine + card: answers each spi_en after 1..4 cycles with the next scripted byte.
  initial begin
    mdone = 0;
    spi_rx = 8'h00;
    forever begin
      @(negedge clk);
      mdone = 0;
      spi_rx = 8'($urandom);
      if (spi_en) begin
        int k;
        logic [7:0] b;
        k = $urandom_range(1, 4);
        b = (rx_q.size() != 0) ? rx_q.pop_front() : 8'hFF;
        repeat (k) @(negedge clk);
        mdone = 1;
        spi_rx = b;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (spi_en) begin
        en_cnt++;
        chk("spi_en_not_back_to_back", {31'd0, prev_en}, 32'd0);
        checks++;
        if (exp_tx.size() == 0) begin
          errors++;
          $display("FAIL unexpected_spi_en: got byte %h cs_n %b expected none", spi_tx, cs_n);
        end else begin
          logic [8:0] e;
          e = exp_tx.pop_front();
          if ({cs_n, spi_tx} !== e) begin
            errors++;
            $display("FAIL tx_byte: got cs_n,byte %h expected %h", {cs_n, spi_tx}, e);
          end
        end
      end
      prev_en = spi_en;
      if (done) begin
        done_cnt++;
        chk("done_one_cycle_after_spi_done", {31'd0, spi_done}, 32'd1);
        checks++;
        if (exp_res.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: got r1 %h timeout %b expected no done", r1, timeout);
        end else begin
          logic [8:0] e;
          e = exp_res.pop_front();
          if ({timeout, r1} !== e) begin
            errors++;
            $display("FAIL result: got timeout,r1 %h expected %h", {timeout, r1}, e);
          end
        end
      end
    end
  end

  // r1pos: poll number (1-based) on which the card answers; 0 or >MAXP means never.
  task automatic start_cmd(input logic [5:0] idx, input logic [31:0] arg,
                           input int r1pos, input logic [7:0] r1val);
    logic [7:0] fr[6];
    int npoll;
    logic hit;
    fr[0] = {2'b01, idx};
    fr[1] = arg[31:24];
    fr[2] = arg[23:16];
    fr[3] = arg[15:8];
    fr[4] = arg[7:0];
    fr[5] = {ref_crc({2'b01, idx, arg}), 1'b1};
    hit = (r1pos >= 1 && r1pos <= MAXP);
    npoll = hit ? r1pos : MAXP;
    for (int i = 0; i < 6; i++) begin
      exp_tx.push_back({1'b0, fr[i]});
      rx_q.push_back(8'($urandom));
    end
    for (int p = 1; p <= npoll; p++) begin
      exp_tx.push_back({1'b0, 8'hFF});
      rx_q.push_back((hit && p == r1pos) ? {1'b0, r1val[6:0]} : 8'($urandom_range(128, 255)));
    end
    exp_tx.push_back({1'b1, 8'hFF});
    rx_q.push_back(8'($urandom));
    exp_res.push_back(hit ? {1'b0, 1'b0, r1val[6:0]} : {1'b1, 8'hFF});
    cmd_index = idx;
    cmd_arg = arg;
    cmd_start = 1;
    @(negedge clk);
    cmd_start = 0;
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_done();
    int s;
    s = done_cnt;
    for (int i = 0; i < 3000 && done_cnt == s; i++) @(negedge clk);
    if (done_cnt == s) begin
      checks++;
      errors++;
      $display("FAIL done_wait: got no done expected done within 3000 cycles");
      exp_tx.delete();
      exp_res.delete();
      rx_q.delete();
    end
    @(negedge clk);
    chk("busy_low_after_done", {31'd0, busy}, 32'd0);
    chk("cs_n_high_after_done", {31'd0, cs_n}, 32'd1);
  endtask

  initial begin
    int base, dc;
    reset = 0;
    cmd_start = 0;
    cmd_index = 0;
    cmd_arg = 0;
    spur = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_r1", {24'd0, r1}, 32'hFF);
    chk("rst_timeout", {31'd0, timeout}, 32'd0);
    chk("rst_cs_n", {31'd0, cs_n}, 32'd1);
    chk("rst_spi_en", {31'd0, spi_en}, 32'd0);
    chk("rst_spi_tx", {24'd0, spi_tx}, 32'hFF);
    reset = 1;
    @(negedge clk);

    start_cmd(6'd0, 32'h0, 2, 8'h01);
    wait_done();
    start_cmd(6'd8, 32'h0000_01AA, 1, 8'h01);
    wait_done();
    start_cmd(6'd17, 32'($urandom), 0, 8'h00);
    wait_done();

    start_cmd(6'd1, 32'h0, 3, 8'h00);
    repeat (5) @(negedge clk);
    cmd_index = 6'd55;
    cmd_arg = 32'hDEAD_BEEF;
    cmd_start = 1;
    @(negedge clk);
    cmd_start = 0;
    wait_done();

    base = en_cnt;
    start_cmd(6'd0, 32'h0, 1, 8'h01);
    for (int i = 0; i < 200 && en_cnt < base + 4; i++) @(negedge clk);
    chk("reached_b3", {31'd0, en_cnt >= base + 4}, 32'd1);
    reset = 0;
    exp_tx.delete();
    exp_res.delete();
    rx_q.delete();
    @(negedge clk);
    reset = 1;
    chk("midrst_cs_n", {31'd0, cs_n}, 32'd1);
    chk("midrst_spi_en", {31'd0, spi_en}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    repeat (12) @(negedge clk);
    chk("late_done_busy", {31'd0, busy}, 32'd0);
    chk("late_done_cs_n", {31'd0, cs_n}, 32'd1);
    start_cmd(6'd0, 32'h0, 2, 8'h01);
    wait_done();

    dc = done_cnt;
    spur = 1;
    @(negedge clk);
    spur = 0;
    repeat (5) @(negedge clk);
    chk("spur_busy", {31'd0, busy}, 32'd0);
    chk("spur_cs_n", {31'd0, cs_n}, 32'd1);
    chk("spur_no_done", done_cnt, dc);

    for (int t = 0; t < 20; t++) begin
      start_cmd(6'($urandom), 32'($urandom), $urandom_range(0, 10), 8'($urandom));
      wait_done();
    end

    chk("tx_queue_drained", exp_tx.size(), 32'd0);
    chk("res_queue_drained", exp_res.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
